// File: rtl/axi4lite_write_slave.sv
// AXI4-Lite write slave: captures one AW and one W beat in any order, commits them
// to a local register port as a one-cycle strobe, then returns a B response.
module axi4lite_write_slave (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [3:0]  strb,
  input  logic        valid
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Decode failure outranks misalignment.
  function automatic logic [1:0] decide_resp(input logic dec_ok, input logic [1:0] addr_lsb);
    logic [1:0] r;
    if (!dec_ok) begin
      r = RESP_DECERR;
    end else if (addr_lsb != 2'b00) begin
      r = RESP_SLVERR;
    end else begin
      r = RESP_OKAY;
    end
    return r;
  endfunction

  logic        aw_full_q, aw_full_d;
  logic        w_full_q, w_full_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;

  logic        aw_hs_s, w_hs_s, commit_s;
  logic [1:0]  resp_s;
  logic        unused_awprot_s;

  assign unused_awprot_s = ^awprot;

  assign aw_hs_s  = awvalid & awready_q;
  assign w_hs_s   = wvalid & wready_q;
  assign commit_s = aw_full_q & w_full_q & ~bvalid_q;
  assign resp_s   = decide_resp(valid, addr_q[1:0]);

  // Next-state for capture flags, payload, response and readies.
  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;

    if (aw_hs_s) begin
      addr_d    = awaddr;
      aw_full_d = 1'b1;
    end else if (commit_s) begin
      aw_full_d = 1'b0;
    end else begin
      aw_full_d = aw_full_q;
    end

    if (w_hs_s) begin
      data_d   = wdata;
      strb_d   = wstrb;
      w_full_d = 1'b1;
    end else if (commit_s) begin
      w_full_d = 1'b0;
    end else begin
      w_full_d = w_full_q;
    end

    // The local strobe fires only for an OKAY commit, in the same cycle bvalid rises.
    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = resp_s;
      we_d     = (resp_s == RESP_OKAY);
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      strb_q    <= 4'd0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign we      = we_q;
  assign addr    = addr_q;
  assign data    = data_q;
  assign strb    = strb_q;

endmodule

// File: tb/tb_axi4lite_write_slave.sv
// Directed bench for axi4lite_write_slave: expected commits are queued when the
// last handshake is driven and checked when the B response appears.
module tb_axi4lite_write_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        we;
  logic [31:0] addr, data;
  logic [3:0]  strb;
  logic        valid;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  r;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_hs = 0;

  axi4lite_write_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .we(we), .addr(addr), .data(data), .strb(strb), .valid(valid)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic v, input logic [31:0] a);
    if (!v) return 2'b11;
    if (a[1:0] != 2'b00) return 2'b10;
    return 2'b00;
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic v);
    exp_t e;
    e.a = a; e.d = d; e.s = s; e.r = model_resp(v, a); e.t = last_hs;
    sb.push_back(e);
  endtask

  task automatic aw_hs(input logic [31:0] a);
    bit ok = 1'b0;
    awvalid = 1'b1; awaddr = a;
    for (int k = 0; k < 20; k++) begin
      if (awready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("aw_ready_timeout", 64'd0, 64'd1);
    last_hs = cyc;
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_hs(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    wvalid = 1'b1; wdata = d; wstrb = s;
    for (int k = 0; k < 20; k++) begin
      if (wready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("w_ready_timeout", 64'd0, 64'd1);
    last_hs = cyc;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic both_hs(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    for (int k = 0; k < 20; k++) begin
      if (awready && wready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("aw_w_ready_timeout", 64'd0, 64'd1);
    last_hs = cyc;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // Waits for the B response, checks it against the scoreboard, optionally stalls bready.
  task automatic wait_b(input int hold);
    exp_t e;
    bit   seen = 1'b0;
    bit   we_early = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < 20; k++) begin
      if (bvalid) begin seen = 1'b1; break; end
      if (we) we_early = 1'b1;
      tick();
    end
    chk("bvalid_seen", 64'(seen), 64'd1);
    chk("we_before_b", 64'(we_early), 64'd0);
    chk("b_latency", 64'(cyc - e.t), 64'd2);
    chk("bresp", 64'(bresp), 64'(e.r));
    chk("we_pulse", 64'(we), 64'(e.r == 2'b00));
    chk("addr", 64'(addr), 64'(e.a));
    chk("data", 64'(data), 64'(e.d));
    chk("strb", 64'(strb), 64'(e.s));
    chk("awready_pending", 64'(awready), 64'd0);
    chk("wready_pending", 64'(wready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      awvalid = 1'b1; awaddr = 32'hFFFF_FFF0;
      wvalid  = 1'b1; wdata  = 32'h0BAD_0BAD; wstrb = 4'b1010;
      tick();
      chk("hold_bvalid", 64'(bvalid), 64'd1);
      chk("hold_bresp", 64'(bresp), 64'(e.r));
      chk("hold_readies", 64'({awready, wready}), 64'd0);
      chk("hold_we", 64'(we), 64'd0);
      chk("hold_addr", 64'(addr), 64'(e.a));
      chk("hold_data", 64'(data), 64'(e.d));
      chk("hold_strb", 64'(strb), 64'(e.s));
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    chk("bvalid_clear", 64'(bvalid), 64'd0);
    chk("we_after", 64'(we), 64'd0);
    chk("readies_back", 64'({awready, wready}), 64'd3);
  endtask

  initial begin
    aresetn = 1'b0; awvalid = 1'b0; awaddr = 32'd0; awprot = 3'b000;
    wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; bready = 1'b1; valid = 1'b1;
    tick(); tick();
    chk("rst_outputs", 64'({awready, wready, bvalid, bresp, we}), 64'd0);
    chk("rst_payload", 64'({addr, data} ^ {60'd0, strb}), 64'd0);
    aresetn = 1'b1;
    chk("readies_before_first_clk", 64'({awready, wready}), 64'd0);
    tick();
    chk("readies_after_release", 64'({awready, wready}), 64'd3);

    // AW and W together.
    awprot = 3'b111;
    both_hs(32'h10, 32'hDEAD_BEEF, 4'b1111);
    push(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    wait_b(0);
    awprot = 3'b000;

    // AW first, W four cycles later.
    aw_hs(32'h24);
    for (int g = 0; g < 4; g++) begin
      chk("gap_aw_first", 64'({awready, wready, bvalid}), 64'b010);
      if (g < 3) tick();
    end
    w_hs(32'h1234, 4'b0011);
    push(32'h24, 32'h1234, 4'b0011, 1'b1);
    wait_b(0);

    // W first, AW three cycles later.
    w_hs(32'hCAFE_0001, 4'b0101);
    for (int g = 0; g < 3; g++) begin
      chk("gap_w_first", 64'({awready, wready, bvalid}), 64'b100);
      if (g < 2) tick();
    end
    aw_hs(32'h08);
    push(32'h08, 32'hCAFE_0001, 4'b0101, 1'b1);
    wait_b(0);

    // Misaligned address: SLVERR, then DECERR takes priority.
    valid = 1'b1;
    both_hs(32'h13, 32'h1111_2222, 4'b1111);
    push(32'h13, 32'h1111_2222, 4'b1111, 1'b1);
    wait_b(0);
    valid = 1'b0;
    both_hs(32'h13, 32'h3333_4444, 4'b1111);
    push(32'h13, 32'h3333_4444, 4'b1111, 1'b0);
    wait_b(0);
    both_hs(32'h0C, 32'h5555_6666, 4'b1111);
    push(32'h0C, 32'h5555_6666, 4'b1111, 1'b0);
    wait_b(0);
    valid = 1'b1;

    // Zero strobes still commit.
    both_hs(32'h20, 32'h7777_8888, 4'b0000);
    push(32'h20, 32'h7777_8888, 4'b0000, 1'b1);
    wait_b(0);

    // Back-pressure on B for six cycles, then a normal write.
    bready = 1'b0;
    both_hs(32'h30, 32'hA5A5_5A5A, 4'b1100);
    push(32'h30, 32'hA5A5_5A5A, 4'b1100, 1'b1);
    wait_b(6);
    both_hs(32'h34, 32'h0F0F_F0F0, 4'b0110);
    push(32'h34, 32'h0F0F_F0F0, 4'b0110, 1'b1);
    wait_b(0);

    // Reset after AW, before W.
    aw_hs(32'h40);
    chk("pre_reset_addr", 64'(addr), 64'h40);
    aresetn = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({awready, wready, bvalid, bresp, we}), 64'd0);
    chk("async_rst_addr", 64'(addr), 64'd0);
    chk("async_rst_data_strb", 64'({data, strb}), 64'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    chk("readies_after_rst", 64'({awready, wready}), 64'd3);
    w_hs(32'h5555_AAAA, 4'b1111);
    for (int g = 0; g < 4; g++) begin
      chk("w_alone_no_commit", 64'({bvalid, we, awready, wready}), 64'b0010);
      tick();
    end
    aw_hs(32'h44);
    push(32'h44, 32'h5555_AAAA, 4'b1111, 1'b1);
    wait_b(0);
    both_hs(32'h48, 32'h0123_4567, 4'b1001);
    push(32'h48, 32'h0123_4567, 4'b1001, 1'b1);
    wait_b(0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
